regfile_writeback: RTL

//  Writeback stage for the dual-issue core; sole driver of the regfile write ports (A_rd_*, B_rd_*).

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_load_queue.sv | 50 +++++
 rtl/regfile_writeback.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: register-file geometry and the rd/data writeback request.
package wb_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;
endpackage

// File: rtl/wb_load_queue.sv
// Load-return FIFO of wb_req_t entries. The head is read combinationally and is valid when the queue is not empty.
// The caller must not push while full or pop while empty.
module wb_load_queue
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clock_i,
   input  logic    reset_i,
   input  logic    push,
   input  wb_req_t push_dat,
   input  logic    pop,
   output wb_req_t head_dat,
   output logic    full,
   output logic    empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = 1;
   localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];
   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
endmodule

// File: rtl/regfile_writeback.sv
// Dual-port writeback: pipe A/B results plus queued load returns; 32-entry busy scoreboard; load starvation flag.
// Results appear on the write ports one cycle after they are valid. Loads wait in the queue while ld_ready_o is low.
// Optional check: WB_ERROR_CHECK_EN enables the sticky err_o protocol flag.
module regfile_writeback
   import wb_pkg::*;
#(
   parameter int LDQ_DEPTH    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  A_res_valid_i,
   input  logic [REG_ADDR_W-1:0] A_res_rd_i,
   input  logic [XLEN-1:0]       A_res_data_i,
   input  logic                  B_res_valid_i,
   input  logic [REG_ADDR_W-1:0] B_res_rd_i,
   input  logic [XLEN-1:0]       B_res_data_i,
   input  logic                  ld_valid_i,
   input  logic [REG_ADDR_W-1:0] ld_rd_i,
   input  logic [XLEN-1:0]       ld_data_i,
   output logic                  ld_ready_o,
   input  logic                  A_iss_set_i,
   input  logic [REG_ADDR_W-1:0] A_iss_rd_i,
   input  logic                  B_iss_set_i,
   input  logic [REG_ADDR_W-1:0] B_iss_rd_i,
   output logic [XLEN-1:0]       busy_o,
   output logic                  ldq_starve_o,
   output logic [REG_ADDR_W-1:0] A_rd_addr_o,
   output logic [XLEN-1:0]       A_rd_data_o,
   output logic                  A_rd_write_o,
   output logic [REG_ADDR_W-1:0] B_rd_addr_o,
   output logic [XLEN-1:0]       B_rd_data_o,
   output logic                  B_rd_write_o,
   output logic                  err_o
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] STARVE_MAX = STARVE_LIMIT[CW-1:0];

   wb_req_t       ldq_head;
   logic          ldq_full;
   logic          ldq_empty;
   logic          ldq_push;
   logic          ldq_pop;
   logic          a_use;
   logic          b_use;
   wb_req_t       a_req;
   wb_req_t       b_req;
   logic [XLEN-1:0] clr_mask;
   logic [XLEN-1:0] set_mask;
   logic [XLEN-1:0] busy_nxt;
   logic [CW-1:0]   starve_cnt;
   logic [CW-1:0]   starve_cnt_nxt;

   assign ld_ready_o = reset_i & ~ldq_full;
   assign ldq_push   = ld_valid_i & ld_ready_o;
   // A load only drains into a port slot that neither pipe claimed this cycle.
   assign ldq_pop    = ~ldq_empty & ~(A_res_valid_i & B_res_valid_i);

   wb_load_queue #(.DEPTH(LDQ_DEPTH)) u_ldq (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .push     (ldq_push),
      .push_dat ('{rd: ld_rd_i, data: ld_data_i}),
      .pop      (ldq_pop),
      .head_dat (ldq_head),
      .full     (ldq_full),
      .empty    (ldq_empty)
   );

   assign a_use = A_res_valid_i | ldq_pop;
   assign a_req = A_res_valid_i ? '{rd: A_res_rd_i, data: A_res_data_i} : ldq_head;
   assign b_use = B_res_valid_i | (ldq_pop & A_res_valid_i);
   assign b_req = B_res_valid_i ? '{rd: B_res_rd_i, data: B_res_data_i} : ldq_head;

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (a_use)       clr_mask[a_req.rd]   = 1'b1;
      if (b_use)       clr_mask[b_req.rd]   = 1'b1;
      if (A_iss_set_i) set_mask[A_iss_rd_i] = 1'b1;
      if (B_iss_set_i) set_mask[B_iss_rd_i] = 1'b1;
      busy_nxt    = (busy_o & ~clr_mask) | set_mask;
      busy_nxt[0] = 1'b0;
   end

   always_comb begin
      starve_cnt_nxt = starve_cnt;
      if (ldq_empty || ldq_pop)        starve_cnt_nxt = '0;
      else if (starve_cnt < STARVE_MAX) starve_cnt_nxt = starve_cnt + CW'(1);
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         A_rd_addr_o  <= '0;
         A_rd_data_o  <= '0;
         A_rd_write_o <= 1'b0;
         B_rd_addr_o  <= '0;
         B_rd_data_o  <= '0;
         B_rd_write_o <= 1'b0;
         busy_o       <= '0;
         starve_cnt   <= '0;
         ldq_starve_o <= 1'b0;
      end else begin
         // x0 writes still occupy the slot and latch data, but never strobe the regfile.
         A_rd_write_o <= a_use && (a_req.rd != '0);
         B_rd_write_o <= b_use && (b_req.rd != '0);
         if (a_use) begin
            A_rd_addr_o <= a_req.rd;
            A_rd_data_o <= a_req.data;
         end
         if (b_use) begin
            B_rd_addr_o <= b_req.rd;
            B_rd_data_o <= b_req.data;
         end
         busy_o       <= busy_nxt;
         starve_cnt   <= starve_cnt_nxt;
         ldq_starve_o <= (starve_cnt_nxt >= STARVE_MAX);
      end
   end

`ifdef WB_ERROR_CHECK_EN
   logic err_hit;
   assign err_hit = (ld_valid_i & ~ld_ready_o)
                  | (A_res_valid_i & B_res_valid_i & (A_res_rd_i == B_res_rd_i) & (A_res_rd_i != '0))
                  | (a_use & (a_req.rd != '0) & ~busy_o[a_req.rd])
                  | (b_use & (b_req.rd != '0) & ~busy_o[b_req.rd]);

   always_ff @(posedge clock_i) begin
      if (!reset_i)     err_o <= 1'b0;
      else if (err_hit) err_o <= 1'b1;
   end
`else
   assign err_o = 1'b0;
`endif
endmodule
